// File: rtl/dark_channel_atmos_est.sv
// Per-frame atmospheric light estimator: finds the brightest dark-channel pixel, clamps it and reports its position.
// Define ATMOS_TEMPORAL_SMOOTH_EN to add IIR smoothing of the estimate across frames (valid one cycle later).
module dark_channel_atmos_est #(
    parameter int ATMOS_MAX = 240,
    parameter int COORD_W   = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   per_frame_vsync,
    input  logic                   per_frame_href,
    input  logic                   per_frame_clken,
    input  logic [7:0]             per_img,
    output logic [7:0]             atmos_light,
    output logic [COORD_W-1:0]     atmos_x,
    output logic [COORD_W-1:0]     atmos_y,
    output logic                   atmos_valid,
    output logic [2*COORD_W-1:0]   frame_pixels
);
    typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

    localparam logic [COORD_W-1:0]   COORD_SAT = '1;
    localparam logic [COORD_W-1:0]   COORD_ONE = COORD_W'(1);
    localparam logic [2*COORD_W-1:0] CNT_SAT   = '1;
    localparam logic [2*COORD_W-1:0] CNT_ONE   = (2*COORD_W)'(1);
    localparam logic [7:0]           A_MAX     = 8'(ATMOS_MAX);

    state_t                 state, state_nxt;
    logic                   vsync_d1, href_d1, armed, line_act;
    logic [7:0]             run_max, a_clamped;
    logic [COORD_W-1:0]     run_x, run_y, x_cnt, y_cnt;
    logic [2*COORD_W-1:0]   pix_cnt;
    logic                   vsync_rise, vsync_fall, href_fall, pix_valid;

    // armed stays low until vsync is seen low after reset, so a frame in flight at reset is not mistaken for a new one
    assign vsync_rise = per_frame_vsync & ~vsync_d1 & armed;
    assign vsync_fall = ~per_frame_vsync & vsync_d1;
    assign href_fall  = ~per_frame_href & href_d1;
    assign pix_valid  = per_frame_vsync & per_frame_href & per_frame_clken;
    assign a_clamped  = (run_max > A_MAX) ? A_MAX : run_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // LATCH re-arms straight into ACCUM when the next frame starts after a single low vsync cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vsync_rise) state_nxt = ACCUM;
            ACCUM:   if (vsync_fall) state_nxt = LATCH;
            LATCH:   state_nxt = vsync_rise ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d1 <= 1'b0;
            href_d1  <= 1'b0;
            armed    <= 1'b0;
            line_act <= 1'b0;
            run_max  <= '0;
            run_x    <= '0;
            run_y    <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            pix_cnt  <= '0;
        end else begin
            vsync_d1 <= per_frame_vsync;
            href_d1  <= per_frame_href;
            armed    <= armed | ~per_frame_vsync;
            if (vsync_rise) begin
                run_max  <= pix_valid ? per_img : 8'd0;
                run_x    <= '0;
                run_y    <= '0;
                x_cnt    <= pix_valid ? COORD_ONE : '0;
                y_cnt    <= '0;
                pix_cnt  <= pix_valid ? CNT_ONE : '0;
                line_act <= pix_valid;
            end else if (state == ACCUM) begin
                if (pix_valid) begin
                    if (pix_cnt == '0 || per_img > run_max) begin
                        run_max <= per_img;
                        run_x   <= x_cnt;
                        run_y   <= y_cnt;
                    end
                    x_cnt    <= (x_cnt == COORD_SAT) ? x_cnt : x_cnt + COORD_ONE;
                    pix_cnt  <= (pix_cnt == CNT_SAT) ? pix_cnt : pix_cnt + CNT_ONE;
                    line_act <= 1'b1;
                end
                if (href_fall) begin
                    x_cnt    <= '0;
                    line_act <= 1'b0;
                    if (line_act && y_cnt != COORD_SAT) y_cnt <= y_cnt + COORD_ONE;
                end
            end
        end
    end

`ifdef ATMOS_TEMPORAL_SMOOTH_EN
    logic       a_loaded;
    logic [9:0] a_sum;

    assign a_sum = 10'(atmos_light) * 10'd3 + 10'(a_clamped);

    // Results are taken during LATCH; the first estimate after reset bypasses the filter
    always_ff @(posedge clk) begin
        if (rst) begin
            atmos_light  <= '0;
            atmos_x      <= '0;
            atmos_y      <= '0;
            atmos_valid  <= 1'b0;
            frame_pixels <= '0;
            a_loaded     <= 1'b0;
        end else begin
            atmos_valid <= 1'b0;
            if (state == LATCH && pix_cnt != '0) begin
                atmos_light  <= a_loaded ? a_sum[9:2] : a_clamped;
                a_loaded     <= 1'b1;
                atmos_x      <= run_x;
                atmos_y      <= run_y;
                frame_pixels <= pix_cnt;
                atmos_valid  <= 1'b1;
            end
        end
    end
`else
    // Results are loaded on the edge that enters LATCH, so valid coincides with the LATCH cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            atmos_light  <= '0;
            atmos_x      <= '0;
            atmos_y      <= '0;
            atmos_valid  <= 1'b0;
            frame_pixels <= '0;
        end else begin
            atmos_valid <= 1'b0;
            if (state == ACCUM && vsync_fall && pix_cnt != '0) begin
                atmos_light  <= a_clamped;
                atmos_x      <= run_x;
                atmos_y      <= run_y;
                frame_pixels <= pix_cnt;
                atmos_valid  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dark_channel_atmos_est.sv
// Directed bench for dark_channel_atmos_est: frame-level reference model checked every cycle plus literal checkpoints.
// Build with ATMOS_TEMPORAL_SMOOTH_EN defined to exercise the smoothed variant.
module tb_dark_channel_atmos_est;
    localparam int CW   = 3;
    localparam int AMAX = 240;
`ifdef ATMOS_TEMPORAL_SMOOTH_EN
    localparam int LAT    = 2;
    localparam bit SMOOTH = 1'b1;
`else
    localparam int LAT    = 1;
    localparam bit SMOOTH = 1'b0;
`endif
    localparam int CSAT = (1 << CW) - 1;
    localparam int PSAT = (1 << (2 * CW)) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0]        pix = 8'd0;
    logic [7:0]        atmos_light;
    logic [CW-1:0]     atmos_x, atmos_y;
    logic              atmos_valid;
    logic [2*CW-1:0]   frame_pixels;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int img [0:15][0:15];

    int held_light = 0, held_x = 0, held_y = 0, held_pix = 0;
    bit smooth_first = 1'b1;
    int pend_at = -1, pend_a = 0, pend_x = 0, pend_y = 0, pend_pix = 0;
    bit checking = 1'b0;
    logic rst_seen = 1'b1;

    dark_channel_atmos_est #(.ATMOS_MAX(AMAX), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img(pix),
        .atmos_light(atmos_light), .atmos_x(atmos_x), .atmos_y(atmos_y),
        .atmos_valid(atmos_valid), .frame_pixels(frame_pixels)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check_output(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected outputs follow the frame model: a reset clears them, a scheduled result replaces them, otherwise they hold
    always @(negedge clk) begin
        if (checking) begin
            bit exp_valid;
            exp_valid = 1'b0;
            if (rst_seen) begin
                held_light = 0; held_x = 0; held_y = 0; held_pix = 0;
                smooth_first = 1'b1;
                pend_at = -1;
            end else if (cyc == pend_at) begin
                exp_valid = 1'b1;
                if (SMOOTH && !smooth_first) held_light = (3 * held_light + pend_a) / 4;
                else held_light = pend_a;
                smooth_first = 1'b0;
                held_x = pend_x; held_y = pend_y; held_pix = pend_pix;
                pend_at = -1;
            end
            check_output("atmos_valid", int'(atmos_valid), int'(exp_valid));
            check_output("atmos_light", int'(atmos_light), held_light);
            check_output("atmos_x", int'(atmos_x), held_x);
            check_output("atmos_y", int'(atmos_y), held_y);
            check_output("frame_pixels", int'(frame_pixels), held_pix);
        end
    end

    task automatic drive(input logic v, input logic hr, input logic ce, input int p);
        @(negedge clk);
        vsync = v; href = hr; clken = ce; pix = 8'(p);
    endtask

    task automatic fill(input int w, input int h, input int val);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y][x] = val;
    endtask

    // Sends img[h][w] as one frame; lead = idle vsync cycles before the first line (0 puts a pixel on the rise cycle)
    task automatic apply_stimulus(input int w, input int h, input int lead, input bit gappy, input bit empty_first);
        int best, bx, by;
        bit first;
        first = 1'b1; best = 0; bx = 0; by = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                if (first || img[y][x] > best) begin
                    best = img[y][x]; bx = x; by = y; first = 1'b0;
                end
        repeat (lead) drive(1'b1, 1'b0, 1'b0, 0);
        if (empty_first) begin
            repeat (3) drive(1'b1, 1'b1, 1'b0, 255);
            drive(1'b1, 1'b0, 1'b0, 0);
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(1'b1, 1'b1, 1'b1, img[y][x]);
                if (gappy) drive(1'b1, 1'b1, 1'b0, 255);
            end
            drive(1'b1, 1'b0, 1'b0, 0);
            drive(1'b1, 1'b0, 1'b0, 0);
        end
        drive(1'b0, 1'b1, 1'b1, 255);
        if (w * h > 0) begin
            pend_at  = cyc + LAT;
            pend_a   = (best > AMAX) ? AMAX : best;
            pend_x   = (bx > CSAT) ? CSAT : bx;
            pend_y   = (by > CSAT) ? CSAT : by;
            pend_pix = (w * h > PSAT) ? PSAT : w * h;
        end
        repeat (4) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_literal(input string tag, input int a, input int x, input int y, input int n);
        check_output({tag, " light"}, int'(atmos_light), a);
        check_output({tag, " x"}, int'(atmos_x), x);
        check_output({tag, " y"}, int'(atmos_y), y);
        check_output({tag, " pixels"}, int'(frame_pixels), n);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        check_literal("reset", 0, 0, 0, 0);
        check_output("reset valid", int'(atmos_valid), 0);

        fill(4, 3, 10); img[1][2] = 200;
        apply_stimulus(4, 3, 2, 1'b0, 1'b0);
        check_literal("single peak", 200, 2, 1, 12);

        fill(4, 3, 5); img[0][1] = 150; img[2][3] = 150;
        apply_stimulus(4, 3, 0, 1'b1, 1'b0);
        check_literal("tie first wins", SMOOTH ? 187 : 150, 1, 0, 12);

        fill(4, 3, 10); img[1][3] = 255;
        apply_stimulus(4, 3, 1, 1'b0, 1'b0);
        check_literal("clamp", SMOOTH ? 200 : 240, 3, 1, 12);

        fill(3, 2, 0);
        apply_stimulus(3, 2, 1, 1'b0, 1'b1);
        check_literal("all zero", SMOOTH ? 150 : 0, 0, 0, 6);

        apply_stimulus(0, 0, 2, 1'b0, 1'b1);
        check_literal("empty frame hold", SMOOTH ? 150 : 0, 0, 0, 6);

        fill(3, 3, 20); img[1][1] = 90;
        apply_stimulus(3, 3, 2, 1'b0, 1'b0);
        check_literal("after empty", SMOOTH ? 135 : 90, 1, 1, 9);

        for (int x = 0; x < 10; x++) img[0][x] = x * 10;
        apply_stimulus(10, 1, 1, 1'b0, 1'b0);
        check_literal("x saturate", SMOOTH ? 123 : 90, 7, 0, 10);

        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 250);
        drive(1'b1, 1'b1, 1'b1, 250);
        @(negedge clk);
        rst = 1'b1; pix = 8'd250;
        drive(1'b1, 1'b1, 1'b1, 60);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 60);
        drive(1'b1, 1'b0, 1'b0, 0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 0);
        check_literal("mid-frame reset", 0, 0, 0, 0);

        fill(3, 2, 30); img[1][2] = 80;
        apply_stimulus(3, 2, 1, 1'b0, 1'b0);
        check_literal("post reset", 80, 2, 1, 6);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        fill(2, 2, 50); img[0][0] = 200;
        apply_stimulus(2, 2, 1, 1'b0, 1'b0);
        check_literal("smooth seed", 200, 0, 0, 4);
        fill(2, 2, 40); img[1][1] = 100;
        apply_stimulus(2, 2, 1, 1'b0, 1'b0);
        check_literal("smooth step", SMOOTH ? 175 : 100, 1, 1, 4);

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
